execute_controller: RTL and testbench
=====================================

EXECUTE_CONTROLLER -- requirements
Module: execute_controller

Interface
REQ-001 The block SHALL have a single parameter: DW, default 16, datapath width in bits.
REQ-002 clk  in  1  sole clock; all state SHALL change on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 flush  in  1  synchronous pipeline flush.
REQ-005 in_valid  in  1  decode stage presents an operation.
REQ-006 in_ready  out  1  controller accepts the operation this cycle.
REQ-007 in_opcode  in  4  operation code.
REQ-008 in_a, in_b  in  DW each  operands.
REQ-009 in_rd  in  3  destination register.
REQ-010 in_wb  in  1  write-back request.
REQ-011 alu_en  out  1  ALU enable.
REQ-012 alu_func  out  4  ALU function control.
REQ-013 alu_a, alu_b  out  DW each  ALU operands.
REQ-014 alu_out  in  DW  ALU result; valid one cycle after an alu_en cycle.
REQ-015 alu_c, alu_n, alu_z  in  1 each  ALU flags; same timing as alu_out.
REQ-016 out_valid  out  1  result available to the memory stage.
REQ-017 out_ready  in  1  memory stage accepts the result.
REQ-018 out_result  out  DW  result.
REQ-019 out_rd  out  3  destination register.
REQ-020 out_wb  out  1  write-back request.
REQ-021 ccr  out  3  condition code register {C,N,Z}.

Function
REQ-022 The FSM SHALL have four states: IDLE, ISSUE, CAPTURE and DONE.
REQ-023 in_ready SHALL be asserted when (IDLE or (DONE and out_ready)) and flush=0.
REQ-024 When in_valid and in_ready are both 1, the block SHALL latch opcode, operands, rd and wb, and go to ISSUE.
REQ-025 ISSUE SHALL last one cycle: alu_en=1 (ALU opcodes only), alu_func, alu_a and alu_b driven from the latched values; then go to CAPTURE.
REQ-026 CAPTURE SHALL last one cycle: latch alu_out into out_result, apply the CCR update, then go to DONE.
REQ-027 DONE SHALL hold out_valid=1 with stable outputs until out_ready=1.
REQ-028 On a DONE handshake, the block SHALL go to ISSUE if a new operation is accepted that same cycle, otherwise to IDLE.
REQ-029 Latency SHALL be 3 cycles from accept to first out_valid; peak throughput SHALL be one operation per 3 cycles.
REQ-030 Opcodes 0001 LOAD, 0010 STORE, 0011 ADD and 0100 NOT SHALL issue to the ALU.
REQ-031 LOAD and STORE SHALL leave the CCR unchanged.
REQ-032 ADD SHALL update C, N and Z from the ALU.
REQ-033 NOT SHALL update N and Z only.
REQ-034 Opcodes 0110 SETC and 0111 CLRC SHALL NOT assert alu_en; in CAPTURE they SHALL set or clear C, give out_result=0 and force out_wb=0.
REQ-035 Opcode 0101 NOP and all other opcodes SHALL NOT assert alu_en, SHALL leave the CCR unchanged, and SHALL give out_result=0 and out_wb=0, with the same 3-cycle timing.
REQ-036 alu_en SHALL be 0 in every state other than ISSUE; alu_a, alu_b and alu_func SHALL hold their last values.
REQ-037 flush=1 SHALL force IDLE at the next edge in any state, drop the in-flight operation and deassert out_valid.
REQ-038 flush takes priority over a CAPTURE in the same cycle: the CCR SHALL NOT be updated.
REQ-039 flush takes priority over in_valid: no operation SHALL be accepted in a flush cycle.

Reset
REQ-040 While reset=0, the block SHALL asynchronously force state=IDLE and set out_valid, alu_en, out_result, out_rd, out_wb, alu_func, alu_a, alu_b and ccr to 0.
REQ-041 in_ready SHALL be 1 in the first cycle after reset release.
REQ-042 Assertion of reset mid-operation SHALL discard the operation and SHALL NOT emit a result.

Structure
REQ-043 Package ex_pkg SHALL hold the opcode constants, the FSM state encoding and the CCR bit indices (C=2, N=1, Z=0).
REQ-044 The CCR SHALL be a sub-module, ccr_reg, with a per-bit update mask, set/clear of C, and the async active-low reset.

Verification
REQ-045 ADD with a=0x9555, b=0xFFFF (ALU returns 0x9554, C=1, N=1, Z=0) -> out_valid 3 cycles after accept, out_result=0x9554, ccr=3'b110.
REQ-046 LOAD with a=0xAA17 after the ADD -> out_result=0xAA17 and ccr unchanged at 3'b110.
REQ-047 out_ready held 0 for 4 cycles in DONE -> out_valid and out_result stable and in_ready=0; on release with in_valid=1 -> back-to-back accept.
REQ-048 flush asserted in CAPTURE of an ADD -> no out_valid, ccr unchanged, state IDLE next cycle.
REQ-049 SETC then CLRC -> alu_en never asserted, C=1 then C=0, out_wb=0 for both.
REQ-050 reset driven to 0 during ISSUE -> all outputs 0 immediately; after release in_ready=1 and no stale result emitted.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared definitions for the execute controller: opcodes, FSM state encoding,
// CCR bit positions and the latched control payload.
package ex_pkg;

  localparam int unsigned OPC_W = 4;
  localparam int unsigned RD_W  = 3;
  localparam int unsigned CCR_W = 3;

  localparam int unsigned CCR_C = 2;
  localparam int unsigned CCR_N = 1;
  localparam int unsigned CCR_Z = 0;

  localparam logic [OPC_W-1:0] OP_LOAD  = 4'b0001;
  localparam logic [OPC_W-1:0] OP_STORE = 4'b0010;
  localparam logic [OPC_W-1:0] OP_ADD   = 4'b0011;
  localparam logic [OPC_W-1:0] OP_NOT   = 4'b0100;
  localparam logic [OPC_W-1:0] OP_NOP   = 4'b0101;
  localparam logic [OPC_W-1:0] OP_SETC  = 4'b0110;
  localparam logic [OPC_W-1:0] OP_CLRC  = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [RD_W-1:0]  rd;
    logic             wb;
  } op_ctl_t;

  // Opcodes that are sent to the ALU and take their result from it.
  function automatic logic is_alu_op(input logic [OPC_W-1:0] op);
    return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_ADD) || (op == OP_NOT);
  endfunction

endpackage

// File: rtl/execute_controller_if.sv
// Decode-side, ALU-side and memory-side signals of the execute controller.
interface execute_controller_if
  import ex_pkg::*;
#(
  parameter int unsigned DW = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [OPC_W-1:0] in_opcode;
  logic [DW-1:0]    in_a;
  logic [DW-1:0]    in_b;
  logic [RD_W-1:0]  in_rd;
  logic             in_wb;

  logic             alu_en;
  logic [OPC_W-1:0] alu_func;
  logic [DW-1:0]    alu_a;
  logic [DW-1:0]    alu_b;
  logic [DW-1:0]    alu_out;
  logic             alu_c;
  logic             alu_n;
  logic             alu_z;

  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_result;
  logic [RD_W-1:0]  out_rd;
  logic             out_wb;
  logic [CCR_W-1:0] ccr;

  modport master (
    input  in_valid, in_opcode, in_a, in_b, in_rd, in_wb,
    input  alu_out, alu_c, alu_n, alu_z, out_ready,
    output in_ready, alu_en, alu_func, alu_a, alu_b,
    output out_valid, out_result, out_rd, out_wb, ccr
  );

  modport slave (
    output in_valid, in_opcode, in_a, in_b, in_rd, in_wb,
    output alu_out, alu_c, alu_n, alu_z, out_ready,
    input  in_ready, alu_en, alu_func, alu_a, alu_b,
    input  out_valid, out_result, out_rd, out_wb, ccr
  );

endinterface

// File: rtl/ccr_reg.sv
// Condition code register {C,N,Z}: masked per-bit load plus explicit set/clear of C.
module ccr_reg
  import ex_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [CCR_W-1:0] upd_mask,
  input  logic [CCR_W-1:0] flags,
  input  logic             set_c,
  input  logic             clr_c,
  output logic [CCR_W-1:0] ccr
);

  logic [CCR_W-1:0] ccr_q;
  logic [CCR_W-1:0] ccr_d;

  always_comb begin
    ccr_d = (ccr_q & ~upd_mask) | (flags & upd_mask);
    if (set_c) begin
      ccr_d[CCR_C] = 1'b1;
    end else if (clr_c) begin
      ccr_d[CCR_C] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ccr_q <= '0;
    end else begin
      ccr_q <= ccr_d;
    end
  end

  assign ccr = ccr_q;

endmodule

// File: rtl/execute_controller.sv
// Execute stage controller: accepts one decoded op, issues it to the ALU,
// captures the result and flags, then holds it for the memory stage.
module execute_controller
  import ex_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input logic                clk,
  input logic                reset,
  input logic                flush,
  execute_controller_if.master bus
);

  state_e           state_q, state_d;
  op_ctl_t          ctl_q, ctl_d;
  logic             alu_en_q, alu_en_d;
  logic [DW-1:0]    alu_a_q, alu_a_d;
  logic [DW-1:0]    alu_b_q, alu_b_d;
  logic             out_valid_q, out_valid_d;
  logic [DW-1:0]    out_result_q, out_result_d;
  logic [RD_W-1:0]  out_rd_q, out_rd_d;
  logic             out_wb_q, out_wb_d;

  logic             in_ready_c;
  logic             accept_c;
  logic [CCR_W-1:0] ccr_mask_c;
  logic [CCR_W-1:0] ccr_flags_c;
  logic             ccr_set_c;
  logic             ccr_clr_c;

  // Next-state, datapath and CCR update control.
  always_comb begin
    state_d      = state_q;
    ctl_d        = ctl_q;
    alu_en_d     = 1'b0;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_rd_d     = out_rd_q;
    out_wb_d     = out_wb_q;
    ccr_mask_c   = '0;
    ccr_set_c    = 1'b0;
    ccr_clr_c    = 1'b0;
    ccr_flags_c  = '0;
    ccr_flags_c[CCR_C] = bus.alu_c;
    ccr_flags_c[CCR_N] = bus.alu_n;
    ccr_flags_c[CCR_Z] = bus.alu_z;

    in_ready_c = ((state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready)) && !flush;
    accept_c   = in_ready_c && bus.in_valid;

    if (flush) begin
      // Flush wins over everything in flight, including a pending CCR update.
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_IDLE;
        ST_ISSUE: state_d = ST_CAPTURE;
        ST_CAPTURE: begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          out_rd_d    = ctl_q.rd;
          if (is_alu_op(ctl_q.opcode)) begin
            out_result_d = bus.alu_out;
            out_wb_d     = ctl_q.wb;
          end else begin
            out_result_d = '0;
            out_wb_d     = 1'b0;
          end
          case (ctl_q.opcode)
            OP_ADD: ccr_mask_c = '1;
            OP_NOT: begin
              ccr_mask_c[CCR_N] = 1'b1;
              ccr_mask_c[CCR_Z] = 1'b1;
            end
            OP_SETC: ccr_set_c = 1'b1;
            OP_CLRC: ccr_clr_c = 1'b1;
            default: ccr_mask_c = '0;
          endcase
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (accept_c) begin
        state_d      = ST_ISSUE;
        ctl_d.opcode = bus.in_opcode;
        ctl_d.rd     = bus.in_rd;
        ctl_d.wb     = bus.in_wb;
        alu_en_d     = is_alu_op(bus.in_opcode);
        alu_a_d      = bus.in_a;
        alu_b_d      = bus.in_b;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      ctl_q        <= '0;
      alu_en_q     <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_rd_q     <= '0;
      out_wb_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ctl_q        <= ctl_d;
      alu_en_q     <= alu_en_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_rd_q     <= out_rd_d;
      out_wb_q     <= out_wb_d;
    end
  end

  ccr_reg u_ccr (
    .clk      (clk),
    .reset    (reset),
    .upd_mask (ccr_mask_c),
    .flags    (ccr_flags_c),
    .set_c    (ccr_set_c),
    .clr_c    (ccr_clr_c),
    .ccr      (bus.ccr)
  );

  assign bus.in_ready   = in_ready_c;
  assign bus.alu_en     = alu_en_q;
  assign bus.alu_func   = ctl_q.opcode;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_rd     = out_rd_q;
  assign bus.out_wb     = out_wb_q;

endmodule

// File: tb/tb_execute_controller.sv
// Bench for execute_controller: a behavioural ALU, an occupancy-level reference
// model feeding a scoreboard, and a separate monitor checking each presented result.
module tb_execute_controller;
  import ex_pkg::*;

  localparam int unsigned DW = 16;

  typedef struct {
    logic [15:0] res;
    logic [2:0]  rd;
    logic        wb;
    logic [2:0]  ccr;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  int n_vec = 0;
  int n_err = 0;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          age;        // -1 idle, 1 issue, 2 capture, 3 holding result
  logic [2:0]  ccr_m;      // committed condition codes
  logic [2:0]  pend_ccr;   // condition codes once the in-flight op captures
  logic [3:0]  cur_op;
  logic [15:0] cur_a;
  logic [15:0] cur_b;

  execute_controller_if #(.DW(DW)) bus ();

  execute_controller #(.DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Environment ALU: {C,N,Z,result}
  function automatic logic [18:0] alu_fn(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] r;
    logic        c;
    c = 1'b0;
    s = '0;
    case (f)
      OP_LOAD:  r = a;
      OP_STORE: r = b;
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[15:0];
        c = s[16];
      end
      OP_NOT:   r = ~a;
      default:  r = '0;
    endcase
    return {c, r[15], (r == 16'h0000), r};
  endfunction

  // ALU result is meaningful only one cycle after alu_en; otherwise garbage.
  always @(posedge clk) begin
    logic [18:0] f;
    if (bus.alu_en === 1'b1) begin
      f = alu_fn(bus.alu_func, bus.alu_a, bus.alu_b);
      bus.alu_out <= f[15:0];
      {bus.alu_c, bus.alu_n, bus.alu_z} <= f[18:16];
    end else begin
      bus.alu_out <= 16'($urandom);
      {bus.alu_c, bus.alu_n, bus.alu_z} <= 3'($urandom);
    end
  end

  function automatic logic uses_alu(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd4);
  endfunction

  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input logic [2:0] rd, input logic wb, input logic [2:0] cc);
    exp_t        e;
    logic [18:0] f;
    f     = alu_fn(op, a, b);
    e.rd  = rd;
    e.ccr = cc;
    e.res = '0;
    e.wb  = 1'b0;
    if (uses_alu(op)) begin
      e.res = f[15:0];
      e.wb  = wb;
    end
    if (op == 4'd3) e.ccr = f[18:16];
    if (op == 4'd4) e.ccr = {cc[2], f[17:16]};
    if (op == 4'd6) e.ccr = cc | 3'b100;
    if (op == 4'd7) e.ccr = cc & 3'b011;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: compares every cycle a result is presented.
  always @(negedge clk) begin
    #2;
    if (reset === 1'b1 && bus.out_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL out_valid_unexpected: got result %0h with nothing outstanding (t=%0t)",
                 bus.out_result, $time);
      end else begin
        mon_e = sbq[0];
        chk("out_result", 32'(bus.out_result), 32'(mon_e.res));
        chk("out_rd", 32'(bus.out_rd), 32'(mon_e.rd));
        chk("out_wb", 32'(bus.out_wb), 32'(mon_e.wb));
        chk("ccr_at_result", 32'(bus.ccr), 32'(mon_e.ccr));
        if (bus.out_ready === 1'b1 || flush === 1'b1) void'(sbq.pop_front());
      end
    end
  end

  task automatic model_clear();
    age    = -1;
    ccr_m  = '0;
    pend_ccr = '0;
    cur_op = '0;
    cur_a  = '0;
    cur_b  = '0;
    sbq.delete();
  endtask

  task automatic chk_zero();
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_alu_en", 32'(bus.alu_en), 32'h0);
    chk("rst_out_result", 32'(bus.out_result), 32'h0);
    chk("rst_out_rd", 32'(bus.out_rd), 32'h0);
    chk("rst_out_wb", 32'(bus.out_wb), 32'h0);
    chk("rst_alu_func", 32'(bus.alu_func), 32'h0);
    chk("rst_alu_a", 32'(bus.alu_a), 32'h0);
    chk("rst_alu_b", 32'(bus.alu_b), 32'h0);
    chk("rst_ccr", 32'(bus.ccr), 32'h0);
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_opcode = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_rd     = '0;
    bus.in_wb     = 1'b0;
    bus.out_ready = 1'b0;
    flush         = 1'b0;
  endtask

  // One clock: drive, check cycle-level behaviour, then advance the model.
  task automatic cyc(input logic v, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                     input logic [2:0] rd, input logic wb, input logic ordy, input logic fl);
    logic mr;
    logic acc;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_opcode = op;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_rd     = rd;
    bus.in_wb     = wb;
    bus.out_ready = ordy;
    flush         = fl;
    #1;
    mr = ((age < 0) || ((age >= 3) && ordy)) && !fl;
    chk("in_ready", 32'(bus.in_ready), 32'(mr));
    chk("out_valid", 32'(bus.out_valid), 32'(age >= 3));
    chk("alu_en", 32'(bus.alu_en), 32'((age == 1) && uses_alu(cur_op)));
    chk("alu_func", 32'(bus.alu_func), 32'(cur_op));
    chk("alu_a", 32'(bus.alu_a), 32'(cur_a));
    chk("alu_b", 32'(bus.alu_b), 32'(cur_b));
    chk("ccr", 32'(bus.ccr), 32'(ccr_m));
    acc = v && mr;
    @(posedge clk);
    if (fl) begin
      if ((age == 1 || age == 2) && sbq.size() > 0) void'(sbq.pop_back());
      age = -1;
    end else if (acc) begin
      sbq.push_back(model(op, a, b, rd, wb, ccr_m));
      pend_ccr = model(op, a, b, rd, wb, ccr_m).ccr;
      cur_op   = op;
      cur_a    = a;
      cur_b    = b;
      age      = 1;
    end else if (age >= 3 && ordy) begin
      age = -1;
    end else if (age == 2) begin
      age   = 3;
      ccr_m = pend_ccr;
    end else if (age == 1) begin
      age = 2;
    end
  endtask

  initial begin
    logic [3:0]  r_op;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic        r_fl;
    int          k;

    reset = 1'b0;
    idle_inputs();
    model_clear();
    repeat (2) @(negedge clk);
    #1;
    chk_zero();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("in_ready_after_reset", 32'(bus.in_ready), 32'h1);

    // ADD with carry and negative result, then back-to-back LOAD
    cyc(1'b1, OP_ADD, 16'h9555, 16'hFFFF, 3'd3, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, OP_NOP, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, OP_NOP, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("add_valid_latency", 32'(bus.out_valid), 32'h1);
    chk("add_result", 32'(bus.out_result), 32'h9554);
    chk("add_ccr", 32'(bus.ccr), 32'h6);
    cyc(1'b1, OP_LOAD, 16'hAA17, 16'h1234, 3'd5, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, OP_NOP, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, OP_NOP, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("load_result", 32'(bus.out_result), 32'hAA17);
    chk("load_ccr", 32'(bus.ccr), 32'h6);

    // Memory stage stalls for 4 cycles, then releases with a new op waiting
    repeat (4) cyc(1'b1, OP_ADD, 16'h0001, 16'h0002, 3'd2, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, OP_ADD, 16'h0001, 16'h0002, 3'd2, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, OP_NOP, 16'h0, 16'h0, 3'd0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, OP_NOP, 16'h0, 16'h0, 3'd0, 1'b0, 1'b1, 1'b0);

    // Flush during CAPTURE of an ADD, with a competing in_valid
    cyc(1'b1, OP_ADD, 16'h7FFF, 16'h0001, 3'd4, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, OP_NOP, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, OP_SETC, 16'h0, 16'h0, 3'd1, 1'b1, 1'b0, 1'b1);
    #1;
    chk("flush_no_valid", 32'(bus.out_valid), 32'h0);
    chk("flush_ccr_kept", 32'(bus.ccr), 32'h0);

    // SETC then CLRC
    cyc(1'b1, OP_SETC, 16'hFFFF, 16'hFFFF, 3'd1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, OP_NOP, 16'h0, 16'h0, 3'd0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, OP_NOP, 16'h0, 16'h0, 3'd0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("setc_ccr", 32'(bus.ccr), 32'h4);
    chk("setc_wb", 32'(bus.out_wb), 32'h0);
    cyc(1'b1, OP_CLRC, 16'hFFFF, 16'hFFFF, 3'd6, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, OP_NOP, 16'h0, 16'h0, 3'd0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, OP_NOP, 16'h0, 16'h0, 3'd0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("clrc_ccr", 32'(bus.ccr), 32'h0);
    chk("clrc_wb", 32'(bus.out_wb), 32'h0);

    // Reset asserted while an ADD is in ISSUE
    cyc(1'b1, OP_ADD, 16'h9555, 16'hFFFF, 3'd7, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("issue_before_reset", 32'(bus.alu_en), 32'h1);
    reset = 1'b0;
    #1;
    chk_zero();
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("in_ready_after_midreset", 32'(bus.in_ready), 32'h1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      k = int'($urandom_range(0, 9));
      if (k < 7) r_op = 4'(k + 1);
      else       r_op = 4'($urandom_range(0, 15));
      k = int'($urandom_range(0, 7));
      if (k == 0)      r_a = 16'h0000;
      else if (k == 1) r_a = 16'hFFFF;
      else             r_a = 16'($urandom);
      r_b  = (k == 2) ? (16'h0000 - r_a) : 16'($urandom);
      r_fl = ($urandom_range(0, 15) == 0);
      cyc(($urandom_range(0, 3) != 0), r_op, r_a, r_b, 3'($urandom), 1'($urandom),
          r_fl ? 1'b0 : ($urandom_range(0, 2) != 0), r_fl);
    end

    repeat (6) cyc(1'b0, OP_NOP, 16'h0, 16'h0, 3'd0, 1'b0, 1'b1, 1'b0);
    if (sbq.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d results never presented, expected 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
